// File: rtl/rt_imp_kernel_pkg.sv
// Shared constants and types for the kernel multiply / accumulate / round / saturate path.
package rt_imp_kernel_pkg;
    localparam int PROD_WIDTH = 23;
    localparam int LATENCY    = 4;
    localparam int TAPS       = 9;
    localparam int ACC_WIDTH  = 32;
    localparam int SHIFT      = 8;
    localparam int OUT_WIDTH  = 8;

    typedef logic [OUT_WIDTH-1:0]        pixel_t;
    typedef logic signed [ACC_WIDTH-1:0] acc_t;
endpackage

// File: rtl/rt_imp_fifo2.sv
// Two-entry first-word-fall-through pixel buffer; head is always visible on dout.
module rt_imp_fifo2
    import rt_imp_kernel_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       push,
    input  logic       pop,
    input  pixel_t     din,
    output pixel_t     dout,
    output logic [1:0] count,
    output logic       full
);
    pixel_t mem [2];
    logic   rd_ptr;
    logic   wr_ptr;
    logic   do_push;
    logic   do_pop;

    assign full    = (count == 2'd2);
    assign do_pop  = pop && (count != 2'd0);
    // When full, a coinciding pop frees the head slot, which is the one being written.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset) begin
            mem[0] <= '0;
            mem[1] <= '0;
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (reset) !(push && full && !pop));
endmodule

// File: rtl/rt_imp_mac_acc_round_sat.sv
// Accumulates TAPS multiplier products per pixel, rounds/shifts/saturates, and buffers results.
module rt_imp_mac_acc_round_sat
    import rt_imp_kernel_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    output logic                  ce_out,
    input  logic                  issue_valid,
    input  logic [PROD_WIDTH-1:0] prod,
    output logic [OUT_WIDTH-1:0]  out_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [3:0]            tap_idx,
    output logic                  sat_sticky
);
    localparam acc_t       ROUND_BIAS = acc_t'(2 ** (SHIFT - 1));
    localparam acc_t       PIX_MAX    = acc_t'(2 ** OUT_WIDTH - 1);
    localparam logic [3:0] LAST_TAP   = 4'(TAPS - 1);

    logic [LATENCY-1:0] vld;
    logic [1:0]         count;
    logic               full;
    logic               consume;
    logic               last_tap;
    logic               push;
    logic               clip;
    acc_t               acc;
    acc_t               acc_next;
    acc_t               rounded;
    pixel_t             pixel;

    // The multiplier and the shadow pipe advance together, so freezing both keeps them aligned.
    assign ce_out   = !full || out_ready;
    assign consume  = ce_out && vld[LATENCY-1];
    assign last_tap = (tap_idx == LAST_TAP);
    assign push     = consume && last_tap;
    assign acc_next = acc + acc_t'($signed(prod));
    assign rounded  = (acc_next + ROUND_BIAS) >>> SHIFT;

    always_comb begin
        clip  = 1'b0;
        pixel = rounded[OUT_WIDTH-1:0];
        if (rounded < 0) begin
            clip  = 1'b1;
            pixel = '0;
        end else if (rounded > PIX_MAX) begin
            clip  = 1'b1;
            pixel = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            vld        <= '0;
            acc        <= '0;
            tap_idx    <= '0;
            sat_sticky <= 1'b0;
        end else begin
            if (ce_out) begin
                vld <= {vld[LATENCY-2:0], issue_valid};
            end
            if (consume) begin
                if (last_tap) begin
                    acc     <= '0;
                    tap_idx <= '0;
                    if (clip) begin
                        sat_sticky <= 1'b1;
                    end
                end else begin
                    acc     <= acc_next;
                    tap_idx <= tap_idx + 4'd1;
                end
            end
        end
    end

    rt_imp_fifo2 u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .pop   (out_ready),
        .din   (pixel),
        .dout  (out_data),
        .count (count),
        .full  (full)
    );

    assign out_valid = (count != 2'd0);
endmodule

// File: doc/rt_imp_mac_acc_round_sat.md
Name: rt_imp_mac_acc_round_sat

Overview:
- Downstream consumer of the 23-bit signed x 8-bit unsigned product stream from the 4-stage, ce-gated kernel multiplier.
- Tracks which multiplier slots carry valid products through a ce-gated valid shadow pipe.
- Accumulates TAPS products per output pixel, then rounds, shifts and saturates to an 8-bit pixel.
- Buffers results in a 2-entry output FIFO with valid/ready. Stalls the multiplier through its ce input when the FIFO cannot accept.

Parameters:
- PROD_WIDTH, 23: product width, signed.
- LATENCY, 4: multiplier pipeline depth, in ce-enabled cycles.
- TAPS, 9: products per output (3x3 kernel).
- ACC_WIDTH, 32: accumulator width, signed.
- SHIFT, 8: fixed-point fraction bits removed at output (SHIFT >= 1).
- OUT_WIDTH, 8: unsigned output pixel width.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous, active-high reset.
- ce_out  out  1  drives the multiplier ce; also acts as the issue-ready to the upstream operand source.
- issue_valid  in  1  an operand pair enters the multiplier this cycle; counted only when ce_out=1.
- prod  in  PROD_WIDTH  multiplier dout.
- out_data  out  OUT_WIDTH  saturated pixel, head of FIFO.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts out_data.
- tap_idx  out  4  taps accumulated for the current pixel (0..TAPS-1).
- sat_sticky  out  1  set when any output has clipped since reset.

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on port reset.
- Reset values:
  - vld shadow = 0; acc = 0; tap_idx = 0.
  - FIFO count = 0; out_valid = 0; out_data = 0.
  - sat_sticky = 0; ce_out = 1 (derived from count = 0).
- Reset mid-operation: in-flight products and the partial accumulation are discarded. The FIFO is flushed.
- Stall rule: ce_out = (count < 2) | out_ready. This is combinational from the count register and out_ready. Nothing is lost when count = 2 and a pop coincides with a push.
- Shadow pipe:
  - vld[LATENCY-1:0] shifts only when ce_out=1.
  - vld[0] <= issue_valid.
- Consume rule: a product is taken only when ce_out=1 and vld[LATENCY-1]=1. When ce_out=0, prod and vld are frozen and no double-accumulation occurs.
- Accumulate: acc_next = acc + sign_extend(prod).
  - If tap_idx < TAPS-1: acc <= acc_next; tap_idx increments.
  - Else (last tap): acc <= 0; tap_idx <= 0; a result is pushed.
- Result arithmetic:
  - r = (acc_next + 2^(SHIFT-1)) >>> SHIFT, arithmetic shift, round-half-up.
  - If r < 0, out = 0. If r > 2^OUT_WIDTH - 1, out = 255. Otherwise out = r[7:0].
  - Either clip sets sat_sticky.
- Latency: the result is on out_data/out_valid 1 cycle after the consuming edge of the last tap, when the FIFO was empty.
- FIFO:
  - Depth 2, first-word-fall-through.
  - Push and pop in the same cycle: count unchanged, order preserved.
  - Pop when empty is ignored.
  - Push when count = 2 cannot occur by construction; an assertion checks it.
- Accumulator width: 9 * 2^22 < 2^31, so acc cannot overflow with the defaults.
- Frame boundaries are not tracked. Alignment is by tap count only.

Decomposition:
- Shared package rt_imp_kernel_pkg:
  - constants PROD_WIDTH, ACC_WIDTH, TAPS, SHIFT, OUT_WIDTH, LATENCY;
  - pixel_t (8-bit unsigned) and acc_t (32-bit signed) typedefs.
- One sub-module, rt_imp_fifo2: 2-entry FWFT buffer with push, pop, count and full outputs.
- Valid shadow, accumulator and round/saturate logic stay in the top.

Test Plan (the bench instantiates a 4-stage ce-gated multiplier model between operand source and DUT):
- Nine products of +256, out_ready=1 -> acc 2304, (2304+128)>>8 = 9 -> out_data = 9; sat_sticky = 0; tap_idx back to 0.
- Taps summing to 384, then a separate pixel summing to 383 -> outputs 2 then 1 (rounding boundary).
- Nine products of -1000 -> out_data = 0 and sat_sticky = 1. Nine products of +40000 (sum 360000 -> 1406) -> out_data = 255.
- Continuous issue_valid with out_ready held 0 for 40 cycles:
  - ce_out falls to 0 exactly when count reaches 2;
  - the vld pipe freezes;
  - after out_ready returns to 1, all pixels appear in order with none dropped or duplicated.
- Random issue_valid gaps (50% density) with random out_ready -> scoreboard matches the reference sum/round/saturate model for 1000 pixels.
- Reset asserted after 5 taps with 3 products in flight -> out_valid=0 and tap_idx=0 next cycle; the next 9 taps of +256 yield exactly 9.
